// File: rtl/hdsp_pkg.sv
// Shared types for the hybrid DSP stage scheduler: vector geometry, requester ids,
// FSM states and the result tag carried alongside the stage pipeline.
// No logic; imported by the scheduler, its arbiter and its interface.
package hdsp_pkg;

  localparam int W     = 12;
  localparam int LANES = 4;
  localparam int VW    = W * LANES;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic v;
    logic id;
    logic last;
  } tag_t;

endpackage

// File: rtl/hdsp_stage_sched_if.sv
// Bundle of requester, stage and result signals around the stage scheduler.
// slave: the scheduler side; master: requesters, stage and result consumer.
// Lanes are packed with lane k at [W*k+W-1:W*k].
interface hdsp_stage_sched_if;
  import hdsp_pkg::*;

  logic          A_VALID;
  logic [VW-1:0] A_DATA;
  logic          A_READY;
  logic          B_VALID;
  logic [VW-1:0] B_DATA;
  logic          B_READY;
  logic [VW-1:0] S_IN;
  logic [VW-1:0] S_OUT;
  logic          R_VALID;
  logic          R_ID;
  logic          R_LAST;
  logic [VW-1:0] R_DATA;
  logic          BUSY;

  modport slave (
    input  A_VALID, A_DATA, B_VALID, B_DATA, S_OUT,
    output A_READY, B_READY, S_IN, R_VALID, R_ID, R_LAST, R_DATA, BUSY
  );

  modport master (
    output A_VALID, A_DATA, B_VALID, B_DATA, S_OUT,
    input  A_READY, B_READY, S_IN, R_VALID, R_ID, R_LAST, R_DATA, BUSY
  );

endinterface

// File: rtl/hdsp_rr_arb2.sv
// Two-way round-robin arbiter: the requester not served last wins a tie.
// Latency: combinational grant.
// Backpressure: none; grant only means something while the caller is idle.
module hdsp_rr_arb2
  import hdsp_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic rr_last,
  output logic gnt_vld,
  output logic gnt_id
);

  // Lone requester wins outright; on a tie the pointer decides
  always_comb begin
    gnt_vld = req_a | req_b;
    if (req_a && req_b) begin
      gnt_id = ~rr_last;
    end else if (req_b) begin
      gnt_id = ID_B;
    end else begin
      gnt_id = ID_A;
    end
  end

endmodule

// File: rtl/hdsp_stage_sched.sv
// Shares one fixed-latency butterfly stage between requesters A and B, frame by frame.
// Latency: result LAT cycles after the accepted beat; one bubble cycle per frame grant.
// Backpressure: only the frame owner sees READY; a stalled owner keeps the grant.
module hdsp_stage_sched
  import hdsp_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int FRAME_LEN = 4
)
(
  input  logic              CLK,
  input  logic              RESET,
  hdsp_stage_sched_if.slave bus
);

  localparam int             BW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0]  BEAT_MAX = BW'(FRAME_LEN - 1);

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          rr_last;
  logic [BW-1:0] beat;
  tag_t          tag [LAT];

  logic          gnt_vld;
  logic          gnt_id;
  logic          hs;
  logic          is_last;
  logic          tag_busy;

  hdsp_rr_arb2 u_arb (
    .req_a   (bus.A_VALID),
    .req_b   (bus.B_VALID),
    .rr_last (rr_last),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, owner-only ready, handshake detection and stage input mux
  always_comb begin
    state_nxt   = state;
    bus.A_READY = 1'b0;
    bus.B_READY = 1'b0;
    hs          = 1'b0;
    is_last     = 1'b0;
    bus.S_IN    = '0;
    case (state)
      IDLE: begin
        if (gnt_vld) state_nxt = BURST;
      end
      BURST: begin
        bus.A_READY = (owner == ID_A);
        bus.B_READY = (owner == ID_B);
        hs          = (owner == ID_A) ? bus.A_VALID : bus.B_VALID;
        is_last     = hs && (beat == BEAT_MAX);
        if (hs) bus.S_IN = (owner == ID_A) ? bus.A_DATA : bus.B_DATA;
        if (is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, beat counting and round-robin pointer update
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner   <= ID_A;
      rr_last <= ID_B;
      beat    <= '0;
    end else begin
      if (state == IDLE && gnt_vld) begin
        owner <= gnt_id;
        beat  <= '0;
      end
      if (hs) begin
        if (is_last) begin
          rr_last <= owner;
          beat    <= '0;
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

  // Tag delay line tracking the stage pipeline; reset drops anything in flight
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LAT; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{v: hs, id: owner, last: is_last};
      for (int i = 1; i < LAT; i++) tag[i] <= tag[i-1];
    end
  end

  // Result presentation gated by the aligned tag, and activity flag
  always_comb begin
    tag_busy = 1'b0;
    for (int i = 0; i < LAT; i++) tag_busy = tag_busy | tag[i].v;
    bus.BUSY    = (state == BURST) | tag_busy;
    bus.R_VALID = tag[LAT-1].v;
    bus.R_ID    = tag[LAT-1].v & tag[LAT-1].id;
    bus.R_LAST  = tag[LAT-1].v & tag[LAT-1].last;
    bus.R_DATA  = tag[LAT-1].v ? bus.S_OUT : '0;
  end

endmodule
